// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver with 16x oversampling, two-flop input synchroniser,
// start-bit glitch rejection and stop-bit framing check.
module uart_rx_frontend #(
    parameter int NB_DATA = 8,
    parameter int DIVISOR = 163,
    parameter int SB_TICK = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic               o_rx_done_tick,
    output logic               o_frame_error,
    output logic               o_busy
);
    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);
    localparam logic [NW-1:0] N_LAST   = NW'(NB_DATA - 1);
    localparam logic [3:0]    S_STOP   = 4'(SB_TICK - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_nx;
    logic               rx_meta, rx_s, rx_prev;
    logic [CW-1:0]      cnt;
    logic               tick;
    logic [3:0]         s, s_nx;
    logic [NW-1:0]      n, n_nx;
    logic [NB_DATA-1:0] b, b_nx, data_nx;
    logic               done_nx, ferr_nx;

    assign tick   = (cnt == CNT_LAST);
    assign o_busy = (state != IDLE);

    // Synchroniser and free-running oversample divider; the divider is never
    // resynced to the frame, so the sample phase varies by up to one tick.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            cnt     <= '0;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            cnt     <= tick ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state          <= IDLE;
            s              <= '0;
            n              <= '0;
            b              <= '0;
            o_rx_data      <= '0;
            o_rx_done_tick <= 1'b0;
            o_frame_error  <= 1'b0;
        end else begin
            state          <= state_nx;
            s              <= s_nx;
            n              <= n_nx;
            b              <= b_nx;
            o_rx_data      <= data_nx;
            o_rx_done_tick <= done_nx;
            o_frame_error  <= ferr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        s_nx     = s;
        n_nx     = n;
        b_nx     = b;
        data_nx  = o_rx_data;
        done_nx  = 1'b0;
        ferr_nx  = 1'b0;
        case (state)
            IDLE: begin
                // Edge, not level: a line stuck low never starts a frame.
                if (rx_prev && !rx_s) begin
                    state_nx = START;
                    s_nx     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s == 4'd7) begin
                        if (!rx_s) begin
                            state_nx = DATA;
                            s_nx     = '0;
                            n_nx     = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        s_nx = s + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s == 4'd15) begin
                        s_nx = '0;
                        b_nx = {rx_s, b[NB_DATA-1:1]};
                        if (n == N_LAST) state_nx = STOP;
                        else             n_nx     = n + NW'(1);
                    end else begin
                        s_nx = s + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s == S_STOP) begin
                        state_nx = IDLE;
                        if (rx_s) begin
                            data_nx = b;
                            done_nx = 1'b1;
                        end else begin
                            ferr_nx = 1'b1;
                        end
                    end else begin
                        s_nx = s + 4'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Serial UART receiver feeding the debug unit's command/byte path: it deserialises 8N1 frames from the host line and delivers each byte as `o_rx_data` plus a one-cycle `o_rx_done_tick`. The debug unit consumes these directly as `i_rx_data` and `i_rx_done_tick`. The block contains its own 16x oversampling tick generator, a two-flop input synchroniser, glitch rejection on the start bit, and stop-bit framing check.

## Interface
- `NB_DATA`, 8: data bits per frame, LSB first.
- `DIVISOR`, 163: clock cycles per oversample tick; bit period = 16*DIVISOR cycles. 163 gives 19200 baud at 50 MHz.
- `SB_TICK`, 16: oversample ticks in the stop bit.
- `i_clock`, input, 1: single system clock; everything is on the rising edge.
- `i_reset`, input, 1: synchronous, active-low reset.
- `i_rx`, input, 1: asynchronous serial line; idles high.
- `o_rx_data`, output, NB_DATA: last correctly framed byte; held until the next good frame.
- `o_rx_done_tick`, output, 1: one-cycle pulse when `o_rx_data` is updated.
- `o_frame_error`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `o_busy`, output, 1: high in any state except IDLE.

## Operation
- Synchroniser:
  - `i_rx` passes through two flops, both reset to 1, giving `rx_s`.
  - A third flop, `rx_prev`, also resets to 1 and is used for edge detection.
- Tick generator:
  - Free-running counter 0..DIVISOR-1.
  - `tick` is high for the one cycle where count == DIVISOR-1; the counter then wraps to 0.
  - The counter never stops or resyncs to frames.
- FSM states: IDLE, START, DATA, STOP.
  - Tick counter `s` is 4 bits; bit counter `n` is $clog2(NB_DATA) bits; shift register `b` is NB_DATA bits.
- IDLE:
  - On `rx_prev`=1 and `rx_s`=0 (falling edge), go to START and clear `s`.
  - A line held low with no preceding high never starts a frame, so a break or line stuck low is ignored.
- START: on each tick, `s` increments.
  - When `s` reaches 7 on a tick (mid start bit) and `rx_s`=0: clear `s` and `n`, go to DATA.
  - When `s` reaches 7 on a tick and `rx_s`=1: treat as a glitch and return to IDLE with no output pulse.
- DATA: on each tick, `s` increments.
  - When `s` reaches 15 on a tick: clear `s` and shift right, `b <= {rx_s, b[NB_DATA-1:1]}`.
  - If `n` == NB_DATA-1, go to STOP; otherwise increment `n`.
- STOP: on each tick, `s` increments.
  - When `s` reaches SB_TICK-1 on a tick and `rx_s`=1: `o_rx_data <= b`, pulse `o_rx_done_tick`, go to IDLE.
  - When `s` reaches SB_TICK-1 on a tick and `rx_s`=0: pulse `o_frame_error`, leave `o_rx_data` unchanged, go to IDLE.
- Reset, including mid-frame, returns the block to:
  - state IDLE; `s`, `n`, `b` and tick counter at 0;
  - `o_rx_data` = 0, `o_rx_done_tick` = 0, `o_frame_error` = 0, `o_busy` = 0;
  - synchroniser flops at 1.
- A partial frame in progress at reset is discarded.

## Timing
- Input latency is 2 cycles from a change on `i_rx` to `rx_s`.
- Start detect happens in the cycle `rx_s` falls. START exit occurs 8 ticks later, at mid start bit.
- Each data bit is sampled 16 ticks after the previous sample point, i.e. at mid bit.
- The stop decision occurs SB_TICK ticks after the last data sample.
- Output pulses are registered:
  - `o_rx_done_tick` or `o_frame_error` is high exactly one cycle, the cycle after the deciding tick.
  - `o_rx_data` changes in that same cycle.
- Back-to-back frames are accepted:
  - The FSM is in IDLE after the stop decision, mid stop bit.
  - The next start bit's falling edge is caught even with zero extra idle time.
- The downstream consumer gets no backpressure. It must take the byte on the pulse cycle, or read `o_rx_data` later, since the value is held.
- Frame period at defaults is about 10*16*DIVISOR = 26080 cycles.

## Test plan
All scenarios use DIVISOR=4, so the bit period is 64 cycles, with `i_reset` low for 5 cycles, then high.
- Reset values: during and after reset with `i_rx`=1 → all outputs 0 and `o_busy`=0; no pulse for 1000 cycles.
- Single byte: send 0x01 (command "write IM"), 8N1 at 64 cycles/bit → exactly one `o_rx_done_tick` with `o_rx_data`=0x01; `o_frame_error` stays 0.
- Back-to-back stream: send 0x03, 0x07, 0x08, 0xA5 with no idle gap → four done pulses, data 0x03, 0x07, 0x08, 0xA5 in order.
- Start glitch: drive `i_rx` low for 10 cycles, then high → no pulse and `o_busy` back to 0 within 40 cycles; a following 0x5A is received correctly.
- Framing error: send 0xFF with the stop bit driven low → `o_frame_error` pulses once, no done pulse, `o_rx_data` retains its previous value. With the line then held low, no new frame starts until the line returns high and falls again.
- Mid-frame reset: assert `i_reset` low during data bit 4 of 0x3C → after release, no pulse and `o_rx_data`=0; a subsequent 0xC3 is received correctly.
